// File: rtl/bram_dual_pipe.sv
// True dual-port RAM of complex {re, im} words. Both ports read and write, the
// read path is pipelined with an optional output register, and the whole array
// is cleared by a sequencer after every reset.
module bram_dual_pipe #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 8,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 En_A,
    input  logic                 En_B,
    input  logic                 We_A,
    input  logic                 We_B,
    input  logic [ADDR_W-1:0]    Addr_A,
    input  logic [ADDR_W-1:0]    Addr_B,
    input  logic [2*WIDTH-1:0]   DI_A,
    input  logic [2*WIDTH-1:0]   DI_B,
    output logic [2*WIDTH-1:0]   DO_A,
    output logic [2*WIDTH-1:0]   DO_B,
    output logic                 Vld_A,
    output logic                 Vld_B,
    output logic                 Init_Busy,
    output logic                 Collision
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DW    = 2 * WIDTH;

    typedef enum logic {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_we;

    logic [DW-1:0] mem [DEPTH];

    logic          acc_a, acc_b, wr_a, wr_b, wr_b_eff, same_addr;
    logic [DW-1:0] rd_a, rd_b;

    logic          s1_vld_a_q, s1_vld_b_q;
    logic [DW-1:0] s1_dat_a_q, s1_dat_b_q;
    logic          col_q;

    assign Init_Busy = (state_q == StClear);
    assign Collision = col_q;

    // Clear sequencer: walk every address writing zero, then go idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
            end
            default: state_d = StClear;
        endcase
    end

    // Sequencer state register; reset restarts the clear from address 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Access qualification and read-data selection (old vs. new per mode).
    always_comb begin
        acc_a     = En_A & ~Init_Busy & ~Rst;
        acc_b     = En_B & ~Init_Busy & ~Rst;
        wr_a      = acc_a & We_A;
        wr_b      = acc_b & We_B;
        same_addr = (Addr_A == Addr_B);
        // Port A wins a same-address double write.
        wr_b_eff  = wr_b & ~(wr_a & same_addr);
        rd_a      = mem[Addr_A];
        rd_b      = mem[Addr_B];
        if (RD_MODE != 0) begin
            if (wr_a) begin
                rd_a = DI_A;
            end
            if (wr_b) begin
                rd_b = (wr_a && same_addr) ? DI_A : DI_B;
            end
        end
    end

    // Array writes: the clear sequencer owns the array while it runs.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (clr_we) begin
                mem[cnt_q] <= '0;
            end else begin
                if (wr_b_eff) begin
                    mem[Addr_B] <= DI_B;
                end
                if (wr_a) begin
                    mem[Addr_A] <= DI_A;
                end
            end
        end
    end

    // First read stage; data only loads on an accepted access so it holds otherwise.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_vld_a_q <= 1'b0;
            s1_vld_b_q <= 1'b0;
            s1_dat_a_q <= '0;
            s1_dat_b_q <= '0;
            col_q      <= 1'b0;
        end else begin
            s1_vld_a_q <= acc_a;
            s1_vld_b_q <= acc_b;
            if (acc_a) begin
                s1_dat_a_q <= rd_a;
            end
            if (acc_b) begin
                s1_dat_b_q <= rd_b;
            end
            col_q <= acc_a & acc_b & same_addr & (We_A | We_B);
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic          out_vld_a_q, out_vld_b_q;
        logic [DW-1:0] out_dat_a_q, out_dat_b_q;

        // Optional output stage; holds the last delivered word between reads.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                out_vld_a_q <= 1'b0;
                out_vld_b_q <= 1'b0;
                out_dat_a_q <= '0;
                out_dat_b_q <= '0;
            end else begin
                out_vld_a_q <= s1_vld_a_q;
                out_vld_b_q <= s1_vld_b_q;
                if (s1_vld_a_q) begin
                    out_dat_a_q <= s1_dat_a_q;
                end
                if (s1_vld_b_q) begin
                    out_dat_b_q <= s1_dat_b_q;
                end
            end
        end

        assign DO_A  = out_dat_a_q;
        assign DO_B  = out_dat_b_q;
        assign Vld_A = out_vld_a_q;
        assign Vld_B = out_vld_b_q;
    end else begin : g_no_out_reg
        assign DO_A  = s1_dat_a_q;
        assign DO_B  = s1_dat_b_q;
        assign Vld_A = s1_vld_a_q;
        assign Vld_B = s1_vld_b_q;
    end

endmodule

// File: tb/tb_bram_dual_pipe.sv
// Bench for bram_dual_pipe: two instances (read-first/no output register and
// write-first/output register) share one stimulus stream and one reference model.
module tb_bram_dual_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic [63:0] di_a = '0, di_b = '0;

    logic [63:0] do_a0, do_b0, do_a1, do_b1;
    logic        vld_a0, vld_b0, vld_a1, vld_b1;
    logic        busy0, busy1, col0, col1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bram_dual_pipe #(.WIDTH(32), .ADDR_W(8), .RD_MODE(0), .OUT_REG(0)) u_dut0 (
        .Clk(clk), .Rst(rst), .En_A(en_a), .En_B(en_b), .We_A(we_a), .We_B(we_b),
        .Addr_A(addr_a), .Addr_B(addr_b), .DI_A(di_a), .DI_B(di_b),
        .DO_A(do_a0), .DO_B(do_b0), .Vld_A(vld_a0), .Vld_B(vld_b0),
        .Init_Busy(busy0), .Collision(col0)
    );

    bram_dual_pipe #(.WIDTH(32), .ADDR_W(8), .RD_MODE(1), .OUT_REG(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .En_A(en_a), .En_B(en_b), .We_A(we_a), .We_B(we_b),
        .Addr_A(addr_a), .Addr_B(addr_b), .DI_A(di_a), .DI_B(di_b),
        .DO_A(do_a1), .DO_B(do_b1), .Vld_A(vld_a1), .Vld_B(vld_b1),
        .Init_Busy(busy1), .Collision(col1)
    );

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic lit_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference model: memory contents plus a per-port delivery schedule.
    // Config 0: read-first, latency 1.  Config 1: write-first, latency 2.
    bit [63:0] mem_m [256];
    int        m_cnt;
    bit        e_busy;
    bit        e_col;
    bit [63:0] e_do  [2][2];
    bit        e_vld [2][2];
    bit [63:0] due_d [2][2][1:2];
    bit        due_v [2][2][1:2];

    always @(posedge clk) begin : model
        bit        aa, ab, wa, wb, sm;
        bit [63:0] rd [2];
        bit        acc [2];
        int        lat;
        if (rst) begin
            e_busy = 1'b1;
            m_cnt  = 0;
            e_col  = 1'b0;
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < 2; p++) begin
                    e_do[c][p]  = '0;
                    e_vld[c][p] = 1'b0;
                    for (int k = 1; k <= 2; k++) begin
                        due_v[c][p][k] = 1'b0;
                        due_d[c][p][k] = '0;
                    end
                end
            end
        end else begin
            aa = en_a && !e_busy;
            ab = en_b && !e_busy;
            wa = aa && we_a;
            wb = ab && we_b;
            sm = (addr_a == addr_b);
            acc[0] = aa;
            acc[1] = ab;
            for (int c = 0; c < 2; c++) begin
                rd[0] = (c == 1 && wa) ? di_a : mem_m[addr_a];
                rd[1] = (c == 1 && wb) ? ((wa && sm) ? di_a : di_b) : mem_m[addr_b];
                lat = c + 1;
                for (int p = 0; p < 2; p++) begin
                    if (acc[p]) begin
                        due_v[c][p][lat] = 1'b1;
                        due_d[c][p][lat] = rd[p];
                    end
                    e_vld[c][p] = due_v[c][p][1];
                    if (due_v[c][p][1]) e_do[c][p] = due_d[c][p][1];
                    due_v[c][p][1] = due_v[c][p][2];
                    due_d[c][p][1] = due_d[c][p][2];
                    due_v[c][p][2] = 1'b0;
                end
            end
            e_col = aa && ab && sm && (we_a || we_b);
            if (e_busy) begin
                mem_m[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == 256) e_busy = 1'b0;
            end else begin
                if (wb && !(wa && sm)) mem_m[addr_b] = di_b;
                if (wa) mem_m[addr_a] = di_a;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            lit_b("vld_a dut0", vld_a0, e_vld[0][0]);
            lit_b("vld_b dut0", vld_b0, e_vld[0][1]);
            lit("do_a dut0", do_a0, e_do[0][0]);
            lit("do_b dut0", do_b0, e_do[0][1]);
            lit_b("vld_a dut1", vld_a1, e_vld[1][0]);
            lit_b("vld_b dut1", vld_b1, e_vld[1][1]);
            lit("do_a dut1", do_a1, e_do[1][0]);
            lit("do_b dut1", do_b1, e_do[1][1]);
            lit_b("collision dut0", col0, e_col);
            lit_b("collision dut1", col1, e_col);
            lit_b("init_busy dut0", busy0, e_busy);
            lit_b("init_busy dut1", busy1, e_busy);
        end
    end

    task automatic drive(input bit ea, input bit wa, input int aa, input logic [63:0] da,
                         input bit eb, input bit wb, input int ab, input logic [63:0] db);
        en_a   = ea;
        we_a   = wa;
        addr_a = 8'(aa);
        di_a   = da;
        en_b   = eb;
        we_b   = wb;
        addr_b = 8'(ab);
        di_b   = db;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic quiet();
        idle();
        idle();
    endtask

    // Called right after the access edge: dut0 delivers now, dut1 one cycle later.
    task automatic pin_after(input bit pb, input logic [63:0] exp0, input logic [63:0] exp1);
        lit_b("pin vld dut0 at L=1", pb ? vld_b0 : vld_a0, 1'b1);
        lit("pin data dut0", pb ? do_b0 : do_a0, exp0);
        lit_b("pin vld dut1 before L=2", pb ? vld_b1 : vld_a1, 1'b0);
        idle();
        lit_b("pin vld dut1 at L=2", pb ? vld_b1 : vld_a1, 1'b1);
        lit("pin data dut1", pb ? do_b1 : do_a1, exp1);
        lit_b("pin vld dut0 after L", pb ? vld_b0 : vld_a0, 1'b0);
    endtask

    task automatic count_busy(input string nm);
        int n = 0;
        while (busy0 && n < 400) begin
            idle();
            n++;
        end
        lit(nm, 64'(n), 64'd256);
    endtask

    initial begin
        // Single-cycle reset, then the full clear.
        @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        lit_b("busy after reset", busy0, 1'b1);
        lit("do_a after reset", do_a1, 64'd0);
        count_busy("init busy cycles");

        // Cleared contents at the edges of the array.
        quiet();
        drive(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);
        pin_after(1'b0, 64'd0, 64'd0);
        quiet();
        drive(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 128, '0);
        pin_after(1'b1, 64'd0, 64'd0);
        quiet();
        drive(1'b1, 1'b0, 255, '0, 1'b0, 1'b0, 0, '0);
        pin_after(1'b0, 64'd0, 64'd0);

        // Latency: write on A, read back on B.
        quiet();
        drive(1'b1, 1'b1, 5, 64'h0000_0001_0000_0002, 1'b0, 1'b0, 0, '0);
        quiet();
        drive(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 5, '0);
        pin_after(1'b1, 64'h0000_0001_0000_0002, 64'h0000_0001_0000_0002);

        // Own-port read-during-write.
        quiet();
        drive(1'b1, 1'b1, 9, 64'd7, 1'b0, 1'b0, 0, '0);
        quiet();
        drive(1'b1, 1'b1, 9, 64'd3, 1'b0, 1'b0, 0, '0);
        pin_after(1'b0, 64'd7, 64'd3);
        quiet();
        drive(1'b1, 1'b0, 9, '0, 1'b0, 1'b0, 0, '0);
        pin_after(1'b0, 64'd3, 64'd3);

        // Double write to one address: A wins, collision flagged.
        quiet();
        drive(1'b1, 1'b1, 4, 64'd11, 1'b1, 1'b1, 4, 64'd22);
        lit_b("dual write collision dut0", col0, 1'b1);
        lit_b("dual write collision dut1", col1, 1'b1);
        pin_after(1'b0, 64'd0, 64'd11);
        quiet();
        drive(1'b1, 1'b0, 4, '0, 1'b0, 1'b0, 0, '0);
        pin_after(1'b0, 64'd11, 64'd11);

        // Cross-port read of an address being written returns old contents.
        quiet();
        drive(1'b1, 1'b1, 6, 64'd5, 1'b0, 1'b0, 0, '0);
        quiet();
        drive(1'b1, 1'b1, 6, 64'd9, 1'b1, 1'b0, 6, '0);
        lit_b("cross collision dut0", col0, 1'b1);
        lit_b("cross collision dut1", col1, 1'b1);
        pin_after(1'b1, 64'd5, 64'd5);
        quiet();
        drive(1'b1, 1'b0, 6, '0, 1'b1, 1'b0, 6, '0);
        lit_b("read-read no collision dut0", col0, 1'b0);
        lit_b("read-read no collision dut1", col1, 1'b0);
        pin_after(1'b0, 64'd9, 64'd9);

        // Mixed traffic on a few addresses, checked by the model only.
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 0, (i % 2) == 1, i % 4, 64'(i * 37 + 1),
                  (i % 4) != 1, (i % 5) == 0, (i / 2) % 4, 64'(i * 1000 + 7));
        end

        // Reset with a read in flight, held for a few cycles.
        quiet();
        drive(1'b1, 1'b0, 4, '0, 1'b0, 1'b0, 0, '0);
        rst = 1'b1;
        idle();
        lit_b("flushed read dut1", vld_a1, 1'b0);
        idle();
        lit_b("flushed read dut1 later", vld_a1, 1'b0);
        idle();
        rst = 1'b0;
        // Reset again once the clear reaches address 100.
        for (int i = 0; i < 100; i++) idle();
        lit_b("busy mid clear", busy0, 1'b1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        count_busy("restarted clear busy cycles");

        quiet();
        drive(1'b1, 1'b0, 4, '0, 1'b0, 1'b0, 0, '0);
        pin_after(1'b0, 64'd0, 64'd0);
        quiet();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
